// File: rtl/led_breathe_pkg.sv
// Shared definitions for the LED breathing envelope.
//   phase_e  : envelope FSM state; the encoding is visible on the phase output
//   duty_max : full-scale duty value for a given PWM width
package led_breathe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    HOLD = 2'd2,
    DOWN = 2'd3
  } phase_e;

  function automatic int duty_max(input int bits);
    return (1 << bits) - 1;
  endfunction

endpackage

// File: rtl/led_breathe_pwm_if.sv
// Signal bundle between the blinker/controller side and the breathing LED block.
//   tick    : one-cycle step strobe (blinker wrap pulse)
//   en      : level enable; 0 sends the envelope dark
//   led_out : registered PWM drive for the LED pin
//   phase   : current envelope FSM state
//   duty    : current target duty
//   peak    : one-cycle pulse on entry to the peak hold
// master = controller side, slave = led_breathe_pwm.
interface led_breathe_pwm_if #(
  parameter int PWM_BITS = 8
);
  logic                tick;
  logic                en;
  logic                led_out;
  logic [1:0]          phase;
  logic [PWM_BITS-1:0] duty;
  logic                peak;

  modport master (output tick, en, input led_out, phase, duty, peak);
  modport slave  (input tick, en, output led_out, phase, duty, peak);
endinterface

// File: rtl/led_pwm_gen.sv
// Free-running PWM renderer.
//   clk, rst : clock, asynchronous active-high reset
//   duty     : requested duty, sampled only at the period boundary
//   led_out  : registered PWM output, high for duty cycles of each 2**PWM_BITS period
module led_pwm_gen
  import led_breathe_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] duty,
  output logic                led_out
);

  localparam logic [PWM_BITS-1:0] MAX_V = PWM_BITS'(duty_max(PWM_BITS));

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_act;

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt  <= '0;
      duty_act <= '0;
      led_out  <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;  // natural wrap MAX -> 0
      // Latch only on the last count so a period is never split between two duties.
      if (pwm_cnt == MAX_V) duty_act <= duty;
      led_out <= (pwm_cnt < duty_act);
    end
  end

endmodule

// File: rtl/led_breathe_pwm.sv
// Breathing LED envelope: steps a duty target up/down on each tick, holds at
// peak and floor, and renders it through led_pwm_gen.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : led_breathe_pwm_if slave (tick, en in; led_out, phase, duty, peak out)
module led_breathe_pwm
  import led_breathe_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter int STEP       = 16,
  parameter int HOLD_TICKS = 4
) (
  input  logic               clk,
  input  logic               rst,
  led_breathe_pwm_if.slave   bus
);

  localparam int                  MAX    = duty_max(PWM_BITS);
  localparam logic [PWM_BITS-1:0] MAX_V  = PWM_BITS'(MAX);
  localparam logic [PWM_BITS:0]   MAX_X  = (PWM_BITS+1)'(MAX);
  localparam logic [PWM_BITS:0]   STEP_X = (PWM_BITS+1)'(STEP);
  localparam int                  HC_W   = $clog2(HOLD_TICKS + 1);
  localparam logic [HC_W-1:0]     HOLD_V = HC_W'(HOLD_TICKS);

  phase_e              state, state_nxt;
  logic [PWM_BITS-1:0] duty, duty_nxt;
  logic [HC_W-1:0]     hold_cnt, hold_cnt_nxt, hold_inc;
  logic                hold_dir, hold_dir_nxt;  // 1 = peak hold, 0 = floor hold
  logic                peak, peak_nxt;
  logic                led_q;

  // One extra bit so the step can overshoot / underflow and be clamped, never wrap.
  logic [PWM_BITS:0] sum, diff;
  logic              sat_hi, sat_lo, hold_done;

  assign sum       = {1'b0, duty} + STEP_X;
  assign diff      = {1'b0, duty} - STEP_X;
  assign sat_hi    = (sum >= MAX_X);
  assign sat_lo    = diff[PWM_BITS] || (diff == '0);  // borrow out means below zero
  assign hold_inc  = hold_cnt + 1'b1;
  assign hold_done = (hold_inc == HOLD_V);

  // State register (FSM state plus the envelope datapath it controls).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      duty     <= '0;
      hold_cnt <= '0;
      hold_dir <= 1'b0;
      peak     <= 1'b0;
    end else begin
      state    <= state_nxt;
      duty     <= duty_nxt;
      hold_cnt <= hold_cnt_nxt;
      hold_dir <= hold_dir_nxt;
      peak     <= peak_nxt;
    end
  end

  // Next-state logic. Dropping en overrides everything, including a coincident tick.
  always_comb begin
    // NOTE: default first so every path assigns the variable and no latch is inferred.
    state_nxt = state;
    if (!bus.en) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: state_nxt = UP;  // entry cycle does not consume a tick
        UP:   if (bus.tick && sat_hi)    state_nxt = HOLD;
        HOLD: if (bus.tick && hold_done) state_nxt = hold_dir ? DOWN : UP;
        DOWN: if (bus.tick && sat_lo)    state_nxt = HOLD;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output / datapath logic.
  always_comb begin
    duty_nxt     = duty;
    hold_cnt_nxt = hold_cnt;
    hold_dir_nxt = hold_dir;
    peak_nxt     = 1'b0;
    if (!bus.en) begin
      duty_nxt     = '0;
      hold_cnt_nxt = '0;
    end else begin
      unique case (state)
        IDLE: duty_nxt = '0;
        UP: if (bus.tick) begin
          duty_nxt = sat_hi ? MAX_V : sum[PWM_BITS-1:0];
          if (sat_hi) begin
            hold_cnt_nxt = '0;
            hold_dir_nxt = 1'b1;
            peak_nxt     = 1'b1;
          end
        end
        HOLD: if (bus.tick) hold_cnt_nxt = hold_done ? '0 : hold_inc;
        DOWN: if (bus.tick) begin
          duty_nxt = sat_lo ? '0 : diff[PWM_BITS-1:0];
          if (sat_lo) begin
            hold_cnt_nxt = '0;
            hold_dir_nxt = 1'b0;
          end
        end
        default: duty_nxt = '0;
      endcase
    end
  end

  led_pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm (
    .clk     (clk),
    .rst     (rst),
    .duty    (duty),
    .led_out (led_q)
  );

  assign bus.led_out = led_q;
  assign bus.phase   = state;
  assign bus.duty    = duty;
  assign bus.peak    = peak;

endmodule

// File: tb/tb_led_breathe_pwm.sv
// Directed bench for led_breathe_pwm with PWM_BITS=4, STEP=4, HOLD_TICKS=2.
// Expected envelope values and LED patterns go into a scoreboard queue when the
// stimulus is driven and are popped when the DUT output is sampled.
module tb_led_breathe_pwm;
  import led_breathe_pkg::*;

  localparam int PB = 4;
  localparam int ST = 4;
  localparam int HT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  led_breathe_pwm_if #(.PWM_BITS(PB)) bus ();

  led_breathe_pwm #(.PWM_BITS(PB), .STEP(ST), .HOLD_TICKS(HT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference period counter: free-running, cleared by reset.
  logic [PB-1:0] m_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) m_cnt <= '0;
    else     m_cnt <= m_cnt + 1'b1;
  end

  typedef struct {
    logic [PB-1:0] duty;
    logic [1:0]    phase;
    logic          peak;
  } exp_t;

  exp_t sb[$];
  logic led_sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  // Drive tick/en for one clock, push the expected result, then pop and compare.
  task automatic step_exp(input logic t, input logic e, input logic [PB-1:0] d,
                          input logic [1:0] p, input logic pk, input string tag);
    exp_t x;
    bus.tick = t;
    bus.en   = e;
    sb.push_back('{duty: d, phase: p, peak: pk});
    clk_step();
    bus.tick = 1'b0;
    n_tests++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL %s.sb observed=empty expected=entry", tag);
    end
    x = sb.pop_front();
    check({tag, ".duty"},  bus.duty,  x.duty);
    check({tag, ".phase"}, bus.phase, x.phase);
    check({tag, ".peak"},  bus.peak,  x.peak);
  endtask

  // Sample led_out for one full period, comparing against the queued pattern.
  // A tick is injected on cycle tick_at (0 = none) to change duty mid-period.
  task automatic pwm_period(input int on_cycles, input int tick_at, input string tag,
                            output int highs);
    logic exp_led;
    highs = 0;
    for (int k = 1; k <= 16; k++) led_sb.push_back(k <= on_cycles);
    for (int k = 1; k <= 16; k++) begin
      bus.tick = (k == tick_at);
      clk_step();
      bus.tick = 1'b0;
      exp_led = led_sb.pop_front();
      if (bus.led_out === 1'b1) highs++;
      check($sformatf("%s.led%0d", tag, k), bus.led_out, exp_led);
      if (k == tick_at) check({tag, ".mid_duty"}, bus.duty, 12);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    int highs;

    bus.tick = 1'b0;
    bus.en   = 1'b0;
    rst      = 1'b1;

    // 1. Reset, then en=0 with free ticks: everything stays dark.
    clk_step();
    clk_step();
    check("rst.phase", bus.phase,   IDLE);
    check("rst.duty",  bus.duty,    0);
    check("rst.led",   bus.led_out, 0);
    check("rst.peak",  bus.peak,    0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step_exp(1'b1, 1'b0, 0, IDLE, 1'b0, $sformatf("t1.off%0d", i));
      check($sformatf("t1.led%0d", i), bus.led_out, 0);
    end

    // 2. Enable with a coincident tick (not consumed), then ramp to saturation.
    step_exp(1'b1, 1'b1, 0,  UP,   1'b0, "t2.enter");
    step_exp(1'b1, 1'b1, 4,  UP,   1'b0, "t2.up4");
    step_exp(1'b1, 1'b1, 8,  UP,   1'b0, "t2.up8");
    step_exp(1'b1, 1'b1, 12, UP,   1'b0, "t2.up12");
    step_exp(1'b1, 1'b1, 15, HOLD, 1'b1, "t2.sat15");
    step_exp(1'b0, 1'b1, 15, HOLD, 1'b0, "t2.peak_once");

    // 3. Peak hold, ramp down with floor saturation, floor hold, back to UP.
    step_exp(1'b1, 1'b1, 15, HOLD, 1'b0, "t3.hold1");
    step_exp(1'b1, 1'b1, 15, DOWN, 1'b0, "t3.hold2");
    step_exp(1'b1, 1'b1, 11, DOWN, 1'b0, "t3.dn11");
    step_exp(1'b1, 1'b1, 7,  DOWN, 1'b0, "t3.dn7");
    step_exp(1'b1, 1'b1, 3,  DOWN, 1'b0, "t3.dn3");
    step_exp(1'b1, 1'b1, 0,  HOLD, 1'b0, "t3.floor");
    step_exp(1'b0, 1'b1, 0,  HOLD, 1'b0, "t3.idle_cyc");
    step_exp(1'b1, 1'b1, 0,  HOLD, 1'b0, "t3.fhold1");
    step_exp(1'b1, 1'b1, 0,  UP,   1'b0, "t3.fhold2");

    // 4. PWM at duty=8 over a full period; a mid-period step to 12 must not
    //    affect it, and the following period shows 12.
    step_exp(1'b1, 1'b1, 4, UP, 1'b0, "t4.up4");
    step_exp(1'b1, 1'b1, 8, UP, 1'b0, "t4.up8");
    guard = 0;
    do begin
      clk_step();
      guard++;
    end while (m_cnt != 0 && guard < 40);
    check("t4.boundary", m_cnt, 0);
    pwm_period(8, 4, "t4.p8", highs);
    check("t4.p8_highs", highs, 8);
    pwm_period(12, 0, "t4.p12", highs);
    check("t4.p12_highs", highs, 12);

    // 5. en drops together with a tick while UP at duty=8.
    step_exp(1'b0, 1'b0, 0, IDLE, 1'b0, "t5.off");
    step_exp(1'b0, 1'b1, 0, UP,   1'b0, "t5.enter");
    step_exp(1'b1, 1'b1, 4, UP,   1'b0, "t5.up4");
    step_exp(1'b1, 1'b1, 8, UP,   1'b0, "t5.up8");
    step_exp(1'b1, 1'b0, 0, IDLE, 1'b0, "t5.en_drop");
    step_exp(1'b1, 1'b0, 0, IDLE, 1'b0, "t5.stay");

    // 6. Asynchronous reset mid-DOWN at duty=7, then restart.
    step_exp(1'b0, 1'b1, 0,  UP,   1'b0, "t6.enter");
    step_exp(1'b1, 1'b1, 4,  UP,   1'b0, "t6.up4");
    step_exp(1'b1, 1'b1, 8,  UP,   1'b0, "t6.up8");
    step_exp(1'b1, 1'b1, 12, UP,   1'b0, "t6.up12");
    step_exp(1'b1, 1'b1, 15, HOLD, 1'b1, "t6.sat");
    step_exp(1'b1, 1'b1, 15, HOLD, 1'b0, "t6.hold1");
    step_exp(1'b1, 1'b1, 15, DOWN, 1'b0, "t6.hold2");
    step_exp(1'b1, 1'b1, 11, DOWN, 1'b0, "t6.dn11");
    step_exp(1'b1, 1'b1, 7,  DOWN, 1'b0, "t6.dn7");
    #3 rst = 1'b1;
    #1;
    check("t6.rst.phase", bus.phase,   IDLE);
    check("t6.rst.duty",  bus.duty,    0);
    check("t6.rst.led",   bus.led_out, 0);
    check("t6.rst.peak",  bus.peak,    0);
    #2 rst = 1'b0;
    step_exp(1'b0, 1'b1, 0, UP, 1'b0, "t6.restart");
    step_exp(1'b1, 1'b1, 4, UP, 1'b0, "t6.up_again");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
